// File: rtl/mem_stage.sv
// Memory stage: byte/half/word data-memory access over a req/ack handshake,
// MEM/WB pipeline register and MEM-stage forwarding outputs.
// Optional feature macro MEM_TIMEOUT_EN: abort an access whose ack does not
// arrive within TIMEOUT_CYCLES request cycles.
module mem_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] aluResult1_PR,
  input  logic [31:0] readDataB1_PR,
  input  logic [4:0]  writeRegister1_PR,
  input  logic        do_writeback1_PR,
  input  logic        MemRead1_PR,
  input  logic        MemWrite1_PR,
  input  logic        MemtoReg1_PR,
  input  logic [1:0]  mem_size,
  input  logic        mem_signed,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  output logic        mem_stall,
  output logic [31:0] Data1_MEM,
  output logic [4:0]  writeRegister1_MEM,
  output logic        do_writeback1_MEM,
  output logic [31:0] Data1_WB,
  output logic [4:0]  writeRegister1_WB,
  output logic        do_writeback1_WB,
  output logic        misalign_err,
  output logic        mem_timeout
);

  typedef enum logic [1:0] {StIdle, StReq, StResp} state_e;

  state_e      state_q, state_d;
  logic        access, misaligned, start;
  logic        abort;      // request gives up this cycle (timeout)
  logic        tmo_abort;  // RESP cycle belongs to an aborted access
  logic [3:0]  be_d;
  logic [31:0] wdata_d;
  logic [31:0] load_buf_q;
  logic [31:0] load_fmt;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign access             = MemRead1_PR | MemWrite1_PR;
  assign start              = (state_q == StIdle) && access && !misaligned;
  assign Data1_MEM          = aluResult1_PR;
  assign writeRegister1_MEM = writeRegister1_PR;
  assign do_writeback1_MEM  = do_writeback1_PR & ~MemtoReg1_PR;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [CntW-1:0] tmo_cnt_q;
  logic            tmo_abort_q;
  logic            mem_timeout_q;

  assign abort       = (state_q == StReq) && !dmem_ack &&
                       (tmo_cnt_q == CntW'(TIMEOUT_CYCLES - 1));
  assign tmo_abort   = tmo_abort_q;
  assign mem_timeout = mem_timeout_q;

  // Request-cycle counter (held at zero outside REQ) and sticky timeout flag.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      tmo_cnt_q     <= '0;
      tmo_abort_q   <= 1'b0;
      mem_timeout_q <= 1'b0;
    end else begin
      if (state_q == StReq) tmo_cnt_q <= tmo_cnt_q + CntW'(1);
      else                  tmo_cnt_q <= '0;
      if (abort)                      tmo_abort_q <= 1'b1;
      else if (state_q == StResp)     tmo_abort_q <= 1'b0;
      if (abort) mem_timeout_q <= 1'b1;
    end
  end
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign abort              = 1'b0;
  assign tmo_abort          = 1'b0;
  assign mem_timeout        = 1'b0;
`endif

  // Alignment check, byte enables and lane-replicated store data.
  always_comb begin
    misaligned = 1'b0;
    be_d       = 4'b1111;
    wdata_d    = readDataB1_PR;
    unique case (mem_size)
      2'b00: begin
        be_d    = 4'b0001 << aluResult1_PR[1:0];
        wdata_d = {4{readDataB1_PR[7:0]}};
      end
      2'b01: begin
        misaligned = aluResult1_PR[0];
        be_d       = aluResult1_PR[1] ? 4'b1100 : 4'b0011;
        wdata_d    = {2{readDataB1_PR[15:0]}};
      end
      default: misaligned = (aluResult1_PR[1:0] != 2'b00);
    endcase
  end

  // Lane select and sign/zero extension of the captured load word.
  always_comb begin
    unique case (aluResult1_PR[1:0])
      2'b00:   ld_byte = load_buf_q[7:0];
      2'b01:   ld_byte = load_buf_q[15:8];
      2'b10:   ld_byte = load_buf_q[23:16];
      default: ld_byte = load_buf_q[31:24];
    endcase
    ld_half = aluResult1_PR[1] ? load_buf_q[31:16] : load_buf_q[15:0];
    unique case (mem_size)
      2'b00:   load_fmt = {{24{mem_signed & ld_byte[7]}}, ld_byte};
      2'b01:   load_fmt = {{16{mem_signed & ld_half[15]}}, ld_half};
      default: load_fmt = load_buf_q;
    endcase
  end

  // Next-state and stall decode.
  always_comb begin
    state_d   = state_q;
    mem_stall = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          mem_stall = 1'b1;
          state_d   = StReq;
        end
      end
      StReq: begin
        mem_stall = 1'b1;
        if (dmem_ack || abort) state_d = StResp;
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM state register.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Data-memory request registers and load buffer.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_be    <= '0;
      dmem_wdata <= '0;
      load_buf_q <= '0;
    end else if (start) begin
      dmem_req   <= 1'b1;
      dmem_we    <= MemWrite1_PR;
      dmem_addr  <= {aluResult1_PR[31:2], 2'b00};
      dmem_be    <= be_d;
      dmem_wdata <= wdata_d;
    end else if (state_q == StReq) begin
      if (dmem_ack) load_buf_q <= dmem_rdata;
      if (dmem_ack || abort) dmem_req <= 1'b0;
    end
  end

  // MEM/WB register; stalled or rejected instructions leave a bubble.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      Data1_WB          <= '0;
      writeRegister1_WB <= '0;
      do_writeback1_WB  <= 1'b0;
      misalign_err      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (!access) begin
            Data1_WB          <= aluResult1_PR;
            writeRegister1_WB <= writeRegister1_PR;
            do_writeback1_WB  <= do_writeback1_PR;
          end else begin
            do_writeback1_WB <= 1'b0;
            if (misaligned) misalign_err <= 1'b1;
          end
        end
        StResp: begin
          Data1_WB          <= MemtoReg1_PR ? load_fmt : aluResult1_PR;
          writeRegister1_WB <= writeRegister1_PR;
          do_writeback1_WB  <= do_writeback1_PR & ~tmo_abort;
        end
        default: do_writeback1_WB <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with a scoreboard of expected MEM/WB results
// and a small data-memory responder with a programmable ack delay.
module tb_mem_stage;

  localparam int TO = 4;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] aluResult1_PR, readDataB1_PR;
  logic [4:0]  writeRegister1_PR;
  logic        do_writeback1_PR, MemRead1_PR, MemWrite1_PR, MemtoReg1_PR;
  logic [1:0]  mem_size;
  logic        mem_signed;
  logic [31:0] dmem_rdata = 32'h0;
  logic        dmem_ack;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        mem_stall;
  logic [31:0] Data1_MEM, Data1_WB;
  logic [4:0]  writeRegister1_MEM, writeRegister1_WB;
  logic        do_writeback1_MEM, do_writeback1_WB, misalign_err, mem_timeout;

  logic        ack_auto = 1'b0;
  logic        ack_man  = 1'b0;
  assign dmem_ack = ack_auto | ack_man;

  mem_stage #(.TIMEOUT_CYCLES(TO)) dut (
    .CLK(CLK), .RESET(RESET),
    .aluResult1_PR(aluResult1_PR), .readDataB1_PR(readDataB1_PR),
    .writeRegister1_PR(writeRegister1_PR), .do_writeback1_PR(do_writeback1_PR),
    .MemRead1_PR(MemRead1_PR), .MemWrite1_PR(MemWrite1_PR), .MemtoReg1_PR(MemtoReg1_PR),
    .mem_size(mem_size), .mem_signed(mem_signed),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .mem_stall(mem_stall),
    .Data1_MEM(Data1_MEM), .writeRegister1_MEM(writeRegister1_MEM),
    .do_writeback1_MEM(do_writeback1_MEM),
    .Data1_WB(Data1_WB), .writeRegister1_WB(writeRegister1_WB),
    .do_writeback1_WB(do_writeback1_WB),
    .misalign_err(misalign_err), .mem_timeout(mem_timeout)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        v;
    logic        chk_data;
  } wb_t;

  wb_t sb[$];
  int  checks = 0;
  int  errors = 0;

  // Memory responder: ack_wait = number of request cycles up to and including
  // the ack cycle (0 = never ack). Snapshots the first request cycle.
  int          ack_wait  = 1;
  int          req_cnt   = 0;
  int          req_total = 0;
  logic [31:0] mem_word  = 32'h0;
  logic [31:0] seen_addr = 32'h0, seen_wdata = 32'h0;
  logic [3:0]  seen_be   = 4'h0;
  logic        seen_we   = 1'b0;

  always @(negedge CLK) begin
    if (dmem_req) begin
      req_total <= req_total + 1;
      if (req_cnt == 0) begin
        seen_addr  <= dmem_addr;
        seen_be    <= dmem_be;
        seen_we    <= dmem_we;
        seen_wdata <= dmem_wdata;
      end
    end
    if (dmem_req && !ack_auto) begin
      if (req_cnt + 1 == ack_wait) begin
        ack_auto   <= 1'b1;
        dmem_rdata <= mem_word;
      end
      req_cnt <= req_cnt + 1;
    end else begin
      ack_auto <= 1'b0;
      if (!dmem_req) req_cnt <= 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_fmt(input logic [31:0] w, input logic [1:0] a,
                                        input logic [1:0] sz, input logic sg);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(w >> (8 * a));
    h = a[1] ? w[31:16] : w[15:0];
    if (sz == 2'b00) return sg ? {{24{b[7]}}, b} : {24'h0, b};
    if (sz == 2'b01) return sg ? {{16{h[15]}}, h} : {16'h0, h};
    return w;
  endfunction

  task automatic drive_idle();
    aluResult1_PR = 32'h0; readDataB1_PR = 32'h0; writeRegister1_PR = 5'd0;
    do_writeback1_PR = 1'b0; MemRead1_PR = 1'b0; MemWrite1_PR = 1'b0;
    MemtoReg1_PR = 1'b0; mem_size = 2'b10; mem_signed = 1'b0;
  endtask

  // Called just after a rising edge; returns just after the edge that loads WB.
  task automatic do_op(input string tag, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [4:0] rd, input logic dowb, input logic rd_en,
                       input logic wr_en, input logic m2r, input logic [1:0] sz,
                       input logic sg, input logic [31:0] rword, input int wait_n);
    logic acc, mis, go;
    int   exp_stall, stalls, req0;
    wb_t  e, got;
    logic [3:0]  ebe;
    logic [31:0] ewd;
    acc = rd_en | wr_en;
    mis = (sz == 2'b01 && addr[0]) || (sz[1] && addr[1:0] != 2'b00);
    go  = acc && !mis;
    exp_stall = go ? 1 + ((wait_n == 0) ? TO : wait_n) : 0;
    ebe = (sz == 2'b00) ? 4'(1 << addr[1:0]) :
          (sz == 2'b01) ? (addr[1] ? 4'hC : 4'h3) : 4'hF;
    ewd = (sz == 2'b00) ? {wd[7:0], wd[7:0], wd[7:0], wd[7:0]} :
          (sz == 2'b01) ? {wd[15:0], wd[15:0]} : wd;

    aluResult1_PR = addr; readDataB1_PR = wd; writeRegister1_PR = rd;
    do_writeback1_PR = dowb; MemRead1_PR = rd_en; MemWrite1_PR = wr_en;
    MemtoReg1_PR = m2r; mem_size = sz; mem_signed = sg;
    ack_wait = wait_n; mem_word = rword;
    req0 = req_total;

    @(negedge CLK);
    chk({tag, "_fwd_data"}, Data1_MEM, addr);
    chk({tag, "_fwd_rd"}, 32'(writeRegister1_MEM), 32'(rd));
    chk({tag, "_fwd_wb"}, 32'(do_writeback1_MEM), 32'(dowb & ~m2r));
    stalls = 0;
    while (mem_stall === 1'b1 && stalls < 64) begin
      stalls++;
      @(negedge CLK);
    end
    e.data     = m2r ? m_fmt(rword, addr[1:0], sz, sg) : addr;
    e.rd       = rd;
    e.chk_data = !mis && !(go && wait_n == 0);
    e.v        = e.chk_data ? dowb : 1'b0;
    sb.push_back(e);

    @(posedge CLK); #1;
    got = sb.pop_front();
    chk({tag, "_stall_cycles"}, 32'(stalls), 32'(exp_stall));
    chk({tag, "_req_cycles"}, 32'(req_total - req0), 32'(go ? exp_stall - 1 : 0));
    chk({tag, "_wb_valid"}, 32'(do_writeback1_WB), 32'(got.v));
    if (got.chk_data) begin
      chk({tag, "_wb_data"}, Data1_WB, got.data);
      chk({tag, "_wb_rd"}, 32'(writeRegister1_WB), 32'(got.rd));
    end
    if (go) begin
      chk({tag, "_addr"}, seen_addr, {addr[31:2], 2'b00});
      chk({tag, "_be"}, 32'(seen_be), 32'(ebe));
      chk({tag, "_we"}, 32'(seen_we), 32'(wr_en));
      if (wr_en) chk({tag, "_wdata"}, seen_wdata, ewd);
    end
  endtask

  initial begin
    RESET = 1'b0;
    drive_idle();
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_req", 32'(dmem_req), 32'd0);
    chk("rst_wb_data", Data1_WB, 32'd0);
    chk("rst_wb_valid", 32'(do_writeback1_WB), 32'd0);
    chk("rst_misalign", 32'(misalign_err), 32'd0);
    chk("rst_timeout", 32'(mem_timeout), 32'd0);
    RESET = 1'b1;
    @(posedge CLK); #1;

    do_op("alu", 32'h1234, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 1);

    // Reset in the middle of an outstanding request.
    aluResult1_PR = 32'h8000; MemRead1_PR = 1'b1; MemtoReg1_PR = 1'b1;
    do_writeback1_PR = 1'b1; writeRegister1_PR = 5'd9; mem_size = 2'b10;
    ack_wait = 0;
    repeat (2) @(posedge CLK);
    #1;
    chk("midreq_req_high", 32'(dmem_req), 32'd1);
    #1 RESET = 1'b0;
    #1;
    chk("midreq_req", 32'(dmem_req), 32'd0);
    chk("midreq_wb_data", Data1_WB, 32'd0);
    chk("midreq_wb_rd", 32'(writeRegister1_WB), 32'd0);
    chk("midreq_wb_valid", 32'(do_writeback1_WB), 32'd0);
    drive_idle();
    ack_man = 1'b1;
    @(negedge CLK);
    RESET = 1'b1;
    @(posedge CLK); #1;
    ack_man = 1'b0;
    @(negedge CLK);
    chk("midreq_idle_stall", 32'(mem_stall), 32'd0);
    chk("midreq_idle_req", 32'(dmem_req), 32'd0);
    @(posedge CLK); #1;

    do_op("lb_s", 32'h1003, 32'h0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 1'b1, 32'h8000_0000, 2);
    do_op("sh", 32'h2002, 32'hABCD_1234, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 32'h0, 1);
    do_op("lw_mis", 32'h3001, 32'h0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h0, 1);
    chk("misalign_set", 32'(misalign_err), 32'd1);
    do_op("lh_u", 32'h4002, 32'h0, 5'd4, 1'b1, 1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 32'h8765_4321, 3);
    do_op("lw", 32'h5000, 32'h0, 5'd6, 1'b1, 1'b1, 1'b0, 1'b1, 2'b11, 1'b0, 32'hDEAD_BEEF, 1);
    do_op("sb", 32'h6001, 32'h0000_00A5, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 32'h0, 1);
    do_op("lh_s", 32'h7000, 32'h0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b1, 2'b01, 1'b1, 32'h0000_9ABC, 2);
    chk("misalign_sticky", 32'(misalign_err), 32'd1);
`ifdef MEM_TIMEOUT_EN
    do_op("tmo", 32'h9000, 32'h0, 5'd10, 1'b1, 1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h0, 0);
    chk("timeout_set", 32'(mem_timeout), 32'd1);
`else
    chk("timeout_tied", 32'(mem_timeout), 32'd0);
`endif
    do_op("alu2", 32'hCAFE_0000, 32'h0, 5'd31, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory stage directly downstream of the execute stage. It consumes the EXE/MEM pipeline registers (ALU result, store data, destination register, memory controls).
- Performs byte, half-word or word data-memory accesses over a req/ack handshake and stalls the pipeline while an access is in flight.
- Drives the MEM/WB pipeline register and the MEM-stage forwarding values that the execute stage consumes.

Parameters:
- TIMEOUT_CYCLES, 255: cycles to wait for dmem_ack before aborting. Used only with MEM_TIMEOUT_EN.

Ports:
- CLK  input  1  clock; all state updates on the rising edge
- RESET  input  1  asynchronous, active-low reset
- aluResult1_PR  input  32  ALU result; memory byte address for loads and stores
- readDataB1_PR  input  32  store data
- writeRegister1_PR  input  5  destination register
- do_writeback1_PR  input  1  instruction writes a register
- MemRead1_PR  input  1  load
- MemWrite1_PR  input  1  store
- MemtoReg1_PR  input  1  writeback value comes from memory
- mem_size  input  2  access size: 00 byte, 01 half, 10 word, 11 treated as word
- mem_signed  input  1  sign-extend load data
- dmem_rdata  input  32  read data, valid with dmem_ack
- dmem_ack  input  1  access complete
- dmem_req  output  1  registered request
- dmem_we  output  1  write enable
- dmem_addr  output  32  word address, {aluResult1_PR[31:2],2'b00}
- dmem_be  output  4  byte enables
- dmem_wdata  output  32  lane-replicated store data
- mem_stall  output  1  upstream must hold all inputs stable while high
- Data1_MEM  output  32  forwarding value (combinational, equals aluResult1_PR)
- writeRegister1_MEM  output  5  forwarding destination (combinational)
- do_writeback1_MEM  output  1  do_writeback1_PR & ~MemtoReg1_PR (combinational)
- Data1_WB  output  32  MEM/WB writeback data
- writeRegister1_WB  output  5  MEM/WB destination
- do_writeback1_WB  output  1  MEM/WB writeback valid
- misalign_err  output  1  sticky misaligned-access flag
- mem_timeout  output  1  sticky timeout flag; constant 0 without MEM_TIMEOUT_EN

Behaviour:
- Access condition: access = MemRead1_PR | MemWrite1_PR.
- Misalignment: misaligned = half with addr[0]=1, or word with addr[1:0]!=0.
- Reset: all registered outputs go to 0, FSM goes to IDLE, dmem_req drops immediately. This applies mid-transaction too, and an outstanding ack is then ignored.
- FSM IDLE:
  - Non-access: mem_stall=0. Next edge, WB registers load aluResult1_PR, writeRegister1_PR and do_writeback1_PR. Latency is 1 cycle.
  - Misaligned access: mem_stall=0, no request, misalign_err<=1. WB registers load do_writeback1_WB=0 (bubble).
  - Aligned access: mem_stall=1. Next edge, dmem_req<=1 and the dmem_addr/be/we/wdata registers load; go to REQ.
- FSM REQ:
  - mem_stall=1 and dmem_req stays high with outputs held.
  - On dmem_ack: capture dmem_rdata into the load buffer, dmem_req<=0, go to RESP.
  - dmem_ack while dmem_req=0 is ignored.
- FSM RESP:
  - mem_stall=0 for this one cycle.
  - Next edge, WB registers load: Data1_WB = formatted load data if MemtoReg1_PR, else aluResult1_PR. do_writeback1_WB = do_writeback1_PR.
  - Go to IDLE.
  - Minimum load/store latency is 3 cycles (IDLE, REQ with same-cycle ack, RESP).
- While stalled in IDLE (aligned access) and REQ, do_writeback1_WB=0, so no duplicate writeback occurs.
- Byte enables and store data:
  - byte: dmem_be = 1 << addr[1:0], dmem_wdata = {4{data[7:0]}}.
  - half: dmem_be = 0011 if addr[1]=0, else 1100; dmem_wdata = {2{data[15:0]}}.
  - word: dmem_be = 1111.
  - For loads, dmem_be follows the same rules and dmem_we=0.
- Load format: select the lane by addr[1:0] (half by addr[1]). Sign-extend if mem_signed, else zero-extend. Word loads pass through.
- misalign_err and mem_timeout are cleared only by RESET.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- Defined:
  - An 8+ bit counter clears on entry to REQ and increments each REQ cycle.
  - When it reaches TIMEOUT_CYCLES with no ack, the access aborts: dmem_req<=0, mem_timeout<=1, go to RESP.
  - The WB registers then load a bubble (do_writeback1_WB=0).
- Undefined:
  - No counter; REQ waits indefinitely.
  - mem_timeout is tied to 0.

Test Plan:
- Reset: assert RESET=0 while in REQ -> dmem_req=0 asynchronously; all WB outputs 0; FSM returns to IDLE.
- ALU op: aluResult1_PR=0x1234, do_writeback1_PR=1, reg 5 -> one cycle later Data1_WB=0x1234, writeRegister1_WB=5, do_writeback1_WB=1, mem_stall never high.
- Signed byte load:
  - Stimulus: addr 0x1003, mem_size=00, mem_signed=1, dmem_rdata=0x80000000, ack delayed 2 cycles.
  - Response: dmem_addr=0x1000, dmem_be=1000, mem_stall high 3 cycles, then Data1_WB=0xFFFFFF80.
- Half store: addr 0x2002, data 0xABCD1234, immediate ack -> dmem_we=1, dmem_be=1100, dmem_wdata=0x12341234, do_writeback1_WB=0.
- Misaligned word load: addr 0x3001 -> no dmem_req, misalign_err=1 and stays 1, do_writeback1_WB=0, mem_stall=0.
- With MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack -> after 4 REQ cycles dmem_req=0, mem_timeout=1, pipeline resumes with a bubble.
